// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Desc     : AHB-Lite encodings and FSM state type for ahb_master_if
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] c_HSIZE_BYTE = 3'b000;
    localparam logic [2:0] c_HSIZE_HALF = 3'b001;
    localparam logic [2:0] c_HSIZE_WORD = 3'b010;

    localparam logic [2:0] c_HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_if
// Desc     : Single-transfer AHB-Lite master driven by core read/write pulses
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_if
    import ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ahb_rd_en,
    input  logic        ahb_wr_en,
    input  logic [31:0] ahb_addr,
    input  logic [31:0] ahb_wr_data,
    input  logic [1:0]  ahb_size,
    output logic [31:0] ahb_rd_data,
    output logic        ahb_rd_vld,
    output logic        ahb_busy,
    output logic        bus_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int unsigned         c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [c_CNT_W-1:0]  w_cnt_inc;

    logic [1:0]  r_htrans;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_data;
    logic        r_rd_vld;
    logic        r_busy;
    logic        r_err;

    logic        w_req;
    logic        w_illegal;
    logic        w_launch;
    logic        w_to_data;
    logic        w_err_pulse;
    logic        w_rd_pulse;
    logic        w_rd_ok;
    logic [31:0] w_hwdata_rep;

    assign w_req     = ahb_rd_en | ahb_wr_en;
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_illegal = 1'b1;
        case ({1'b0, ahb_size})
            c_HSIZE_BYTE: w_illegal = 1'b0;
            c_HSIZE_HALF: w_illegal = ahb_addr[0];
            c_HSIZE_WORD: w_illegal = (ahb_addr[1:0] != 2'b00);
            default:      w_illegal = 1'b1;
        endcase
    end

    // Byte and halfword writes are mirrored onto every lane the slave may pick.
    always_comb begin
        w_hwdata_rep = r_wdata;
        case (r_hsize)
            c_HSIZE_BYTE: w_hwdata_rep = {4{r_wdata[7:0]}};
            c_HSIZE_HALF: w_hwdata_rep = {2{r_wdata[15:0]}};
            default:      w_hwdata_rep = r_wdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_launch     = 1'b0;
        w_to_data    = 1'b0;
        w_err_pulse  = 1'b0;
        w_rd_pulse   = 1'b0;
        w_rd_ok      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        w_state_next = ST_RESP;
                        w_err_pulse  = 1'b1;
                        w_rd_pulse   = ~ahb_wr_en;
                    end else begin
                        w_state_next = ST_ADDR;
                        w_launch     = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                w_cnt_next = '0;
                if (HREADY) begin
                    w_state_next = ST_DATA;
                    w_to_data    = 1'b1;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    w_cnt_next = '0;
                    if (HRESP) begin
                        w_state_next = ST_RESP;
                        w_err_pulse  = 1'b1;
                        w_rd_pulse   = ~r_hwrite;
                    end else if (r_hwrite) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_RESP;
                        w_rd_pulse   = 1'b1;
                        w_rd_ok      = 1'b1;
                    end
                end else if (w_cnt_inc == c_CNT_MAX) begin
                    // A stalled slave is abandoned rather than hanging the core.
                    w_cnt_next   = '0;
                    w_state_next = ST_RESP;
                    w_err_pulse  = 1'b1;
                    w_rd_pulse   = ~r_hwrite;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_htrans  <= c_HTRANS_IDLE;
            r_haddr   <= '0;
            r_hwrite  <= 1'b0;
            r_hsize   <= '0;
            r_hwdata  <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_pulse;
            r_err    <= w_err_pulse;
            r_busy   <= (w_state_next != ST_IDLE);
            if (w_rd_pulse) begin
                r_rd_data <= w_rd_ok ? HRDATA : 32'h0;
            end
            if (w_launch) begin
                r_htrans <= c_HTRANS_NONSEQ;
                r_haddr  <= ahb_addr;
                r_hwrite <= ahb_wr_en;
                r_hsize  <= {1'b0, ahb_size};
                r_wdata  <= ahb_wr_data;
            end
            if (w_to_data) begin
                r_htrans <= c_HTRANS_IDLE;
                r_hwdata <= w_hwdata_rep;
            end
        end
    end

    assign ahb_rd_data = r_rd_data;
    assign ahb_rd_vld  = r_rd_vld;
    assign ahb_busy    = r_busy;
    assign bus_err     = r_err;
    assign HADDR       = r_haddr;
    assign HTRANS      = r_htrans;
    assign HWRITE      = r_hwrite;
    assign HSIZE       = r_hsize;
    assign HBURST      = c_HBURST_SINGLE;
    assign HPROT       = HPROT_VAL;
    assign HWDATA      = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_if
// Desc     : Directed self-checking bench for ahb_master_if
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_master_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ahb_rd_en = 1'b0;
    logic        ahb_wr_en = 1'b0;
    logic [31:0] ahb_addr = '0;
    logic [31:0] ahb_wr_data = '0;
    logic [1:0]  ahb_size = '0;
    logic [31:0] ahb_rd_data;
    logic        ahb_rd_vld;
    logic        ahb_busy;
    logic        bus_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;
    int pulse_cnt;

    always #5 clk = ~clk;

    ahb_master_if #(
        .TIMEOUT_CYCLES (4),
        .HPROT_VAL      (4'b0011)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ahb_rd_en   (ahb_rd_en),
        .ahb_wr_en   (ahb_wr_en),
        .ahb_addr    (ahb_addr),
        .ahb_wr_data (ahb_wr_data),
        .ahb_size    (ahb_size),
        .ahb_rd_data (ahb_rd_data),
        .ahb_rd_vld  (ahb_rd_vld),
        .ahb_busy    (ahb_busy),
        .bus_err     (bus_err),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size);
        ahb_rd_en   = rd;
        ahb_wr_en   = wr;
        ahb_addr    = addr;
        ahb_wr_data = data;
        ahb_size    = size;
    endtask

    task automatic clear_req();
        ahb_rd_en = 1'b0;
        ahb_wr_en = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_htrans", 32'(HTRANS), 32'h0);
        check_val("rst_haddr", HADDR, 32'h0);
        check_val("rst_hwrite", 32'(HWRITE), 32'h0);
        check_val("rst_hsize", 32'(HSIZE), 32'h0);
        check_val("rst_hwdata", HWDATA, 32'h0);
        check_val("rst_hburst", 32'(HBURST), 32'h0);
        check_val("rst_hprot", 32'(HPROT), 32'h3);
        check_val("rst_rd_data", ahb_rd_data, 32'h0);
        check_val("rst_flags", {29'h0, ahb_rd_vld, ahb_busy, bus_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Zero-wait word read, then a back-to-back byte read
        HRDATA = 32'h1234_5678;
        request(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2'b10);
        tick();
        clear_req();
        check_val("rd_addr_htrans", 32'(HTRANS), 32'h2);
        check_val("rd_addr_haddr", HADDR, 32'h0000_0010);
        check_val("rd_addr_hsize", 32'(HSIZE), 32'h2);
        check_val("rd_addr_hwrite", 32'(HWRITE), 32'h0);
        check_val("rd_addr_busy", 32'(ahb_busy), 32'h1);
        tick();
        check_val("rd_data_htrans", 32'(HTRANS), 32'h0);
        check_val("rd_data_vld", 32'(ahb_rd_vld), 32'h0);
        tick();
        check_val("rd_vld", 32'(ahb_rd_vld), 32'h1);
        check_val("rd_data", ahb_rd_data, 32'h1234_5678);
        check_val("rd_no_err", 32'(bus_err), 32'h0);
        check_val("rd_busy_resp", 32'(ahb_busy), 32'h1);
        tick();
        check_val("rd_vld_drop", 32'(ahb_rd_vld), 32'h0);
        check_val("rd_busy_low", 32'(ahb_busy), 32'h0);
        HRDATA = 32'hCAFE_F00D;
        request(1'b1, 1'b0, 32'h0000_0002, 32'h0, 2'b00);
        tick();
        clear_req();
        check_val("b2b_htrans", 32'(HTRANS), 32'h2);
        check_val("b2b_haddr", HADDR, 32'h0000_0002);
        check_val("b2b_hsize", 32'(HSIZE), 32'h0);
        tick();
        tick();
        check_val("b2b_vld", 32'(ahb_rd_vld), 32'h1);
        check_val("b2b_data", ahb_rd_data, 32'hCAFE_F00D);
        tick();

        // Misaligned halfword read: no bus transfer, error plus zero read data
        HRDATA = 32'hDEAD_BEEF;
        request(1'b1, 1'b0, 32'h0000_0001, 32'h0, 2'b01);
        tick();
        clear_req();
        check_val("mis_htrans", 32'(HTRANS), 32'h0);
        check_val("mis_err", 32'(bus_err), 32'h1);
        check_val("mis_vld", 32'(ahb_rd_vld), 32'h1);
        check_val("mis_data", ahb_rd_data, 32'h0);
        tick();
        check_val("mis_err_drop", 32'(bus_err), 32'h0);
        check_val("mis_busy_low", 32'(ahb_busy), 32'h0);

        // Illegal size with read and write together: write wins, so no rd_vld
        request(1'b1, 1'b1, 32'h0000_0000, 32'h0, 2'b11);
        tick();
        clear_req();
        check_val("ill_err", 32'(bus_err), 32'h1);
        check_val("ill_vld", 32'(ahb_rd_vld), 32'h0);
        check_val("ill_htrans", 32'(HTRANS), 32'h0);
        tick();

        // Aligned read+write together: write wins, zero-wait write has no pulse
        request(1'b1, 1'b1, 32'h0000_0008, 32'h1122_3344, 2'b10);
        tick();
        clear_req();
        check_val("rw_hwrite", 32'(HWRITE), 32'h1);
        check_val("rw_htrans", 32'(HTRANS), 32'h2);
        tick();
        check_val("rw_hwdata", HWDATA, 32'h1122_3344);
        tick();
        check_val("rw_busy_low", 32'(ahb_busy), 32'h0);
        check_val("rw_no_pulse", {30'h0, ahb_rd_vld, bus_err}, 32'h0);

        // Byte write with three wait states in the data phase
        request(1'b0, 1'b1, 32'h0000_0003, 32'h1234_56AB, 2'b00);
        busy_cnt  = 0;
        pulse_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) begin
                clear_req();
                check_val("bw_hsize", 32'(HSIZE), 32'h0);
                check_val("bw_hwrite", 32'(HWRITE), 32'h1);
                check_val("bw_haddr", HADDR, 32'h0000_0003);
            end
            if (k == 1) begin
                check_val("bw_hwdata", HWDATA, 32'hABAB_ABAB);
                HREADY = 1'b0;
            end
            if (k == 4) HREADY = 1'b1;
            busy_cnt  += int'(ahb_busy);
            pulse_cnt += int'(ahb_rd_vld) + int'(bus_err);
        end
        check_val("bw_busy_cycles", 32'(busy_cnt), 32'd5);
        check_val("bw_pulses", 32'(pulse_cnt), 32'd0);

        // Two-cycle error response on a read
        HRDATA = 32'hDEAD_BEEF;
        request(1'b1, 1'b0, 32'h0000_0020, 32'h0, 2'b10);
        tick();
        clear_req();
        tick();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();
        check_val("er_first_err", 32'(bus_err), 32'h0);
        check_val("er_first_vld", 32'(ahb_rd_vld), 32'h0);
        check_val("er_first_busy", 32'(ahb_busy), 32'h1);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        check_val("er_err", 32'(bus_err), 32'h1);
        check_val("er_vld", 32'(ahb_rd_vld), 32'h1);
        check_val("er_data", ahb_rd_data, 32'h0);
        tick();
        check_val("er_idle_busy", 32'(ahb_busy), 32'h0);
        check_val("er_err_drop", 32'(bus_err), 32'h0);

        // Data-phase timeout after four stalled cycles; a request while busy is dropped
        request(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2'b10);
        tick();
        clear_req();
        tick();
        HREADY = 1'b0;
        tick();
        request(1'b0, 1'b1, 32'h0000_0080, 32'h5555_5555, 2'b10);
        tick();
        clear_req();
        check_val("to_haddr_kept", HADDR, 32'h0000_0040);
        check_val("to_no_err_2", 32'(bus_err), 32'h0);
        tick();
        check_val("to_no_err_3", 32'(bus_err), 32'h0);
        tick();
        check_val("to_err", 32'(bus_err), 32'h1);
        check_val("to_vld", 32'(ahb_rd_vld), 32'h1);
        check_val("to_data", ahb_rd_data, 32'h0);
        HREADY = 1'b1;
        tick();
        check_val("to_busy_low", 32'(ahb_busy), 32'h0);
        tick();
        check_val("to_dropped_htrans", 32'(HTRANS), 32'h0);
        check_val("to_dropped_busy", 32'(ahb_busy), 32'h0);

        // Asynchronous reset in the middle of a stalled write
        request(1'b0, 1'b1, 32'h0000_0100, 32'h55AA_55AA, 2'b10);
        tick();
        clear_req();
        tick();
        check_val("mr_hwdata_pre", HWDATA, 32'h55AA_55AA);
        HREADY = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mr_htrans", 32'(HTRANS), 32'h0);
        check_val("mr_haddr", HADDR, 32'h0);
        check_val("mr_hwdata", HWDATA, 32'h0);
        check_val("mr_hwrite", 32'(HWRITE), 32'h0);
        check_val("mr_busy", 32'(ahb_busy), 32'h0);
        #1;
        rst_n  = 1'b1;
        HREADY = 1'b1;
        pulse_cnt = 0;
        busy_cnt  = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulse_cnt += int'(ahb_rd_vld) + int'(bus_err);
            busy_cnt  += int'(ahb_busy);
        end
        check_val("mr_no_pulse", 32'(pulse_cnt), 32'd0);
        check_val("mr_stays_idle", 32'(busy_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_master_if.md
AHB_MASTER_IF -- requirements
Module: ahb_master_if

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of consecutive HREADY-low cycles tolerated in the data phase.
REQ-002 The module SHALL have parameter HPROT_VAL, default 4'b0011, giving the constant HPROT value (non-cacheable, non-bufferable, privileged data).
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ahb_rd_en  input  1  core read request, one-cycle pulse.
REQ-006 ahb_wr_en  input  1  core write request, one-cycle pulse.
REQ-007 ahb_addr  input  32  request byte address.
REQ-008 ahb_wr_data  input  32  write data, right-justified.
REQ-009 ahb_size  input  2  transfer size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 ahb_rd_data  output  32  read data, raw 32-bit bus lane.
REQ-011 ahb_rd_vld  output  1  one-cycle pulse that qualifies ahb_rd_data.
REQ-012 ahb_busy  output  1  transfer in progress; new requests are ignored.
REQ-013 bus_err  output  1  one-cycle pulse on error, misalignment or timeout.
REQ-014 The AHB-Lite master ports SHALL be HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HWDATA out 32, HRDATA in 32, HREADY in 1 and HRESP in 1.

Function
REQ-015 The FSM SHALL have the states IDLE, ADDR, DATA and RESP.
REQ-016 In IDLE, a request SHALL be accepted when ahb_rd_en or ahb_wr_en is high; address, size, direction and data are latched on that edge.
REQ-017 If ahb_rd_en and ahb_wr_en are high together, the write SHALL win.
REQ-018 ahb_busy SHALL equal (state != IDLE) and is registered; a request arriving while busy SHALL be dropped with no side effect.
REQ-019 Misaligned or illegal requests SHALL issue no bus transfer: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-020 A misaligned or illegal request SHALL go IDLE->RESP, pulse bus_err, and for a read also pulse ahb_rd_vld with ahb_rd_data=0.
REQ-021 In ADDR the module SHALL drive HTRANS=NONSEQ, HADDR, HWRITE, HSIZE={0,size}, HBURST=SINGLE and HPROT=HPROT_VAL.
REQ-022 The module SHALL stay in ADDR while HREADY=0 and move to DATA on HREADY=1.
REQ-023 In DATA, HTRANS SHALL be IDLE.
REQ-024 In DATA, HWDATA SHALL carry the write data replicated per size: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-025 A DATA cycle with HREADY=1 and HRESP=0 SHALL complete the transfer: a read captures HRDATA into ahb_rd_data and pulses ahb_rd_vld on the next cycle; a write completes silently; the FSM returns to IDLE.
REQ-026 A DATA cycle with HREADY=1 and HRESP=1 SHALL complete with a bus_err pulse, and for a read ahb_rd_vld with data 0.
REQ-027 A DATA cycle with HRESP=1 and HREADY=0 (first error cycle) SHALL only continue waiting.
REQ-028 A saturating counter SHALL count consecutive HREADY-low cycles in DATA; on reaching TIMEOUT_CYCLES the module SHALL abort to RESP with bus_err (and rd_vld with data 0 for a read).
REQ-029 A zero-wait read SHALL take: request at edge T, ADDR during T..T+1, DATA during T+1..T+2, ahb_rd_vld high during T+2..T+3, ahb_busy low again from T+3.
REQ-030 ahb_rd_vld and bus_err SHALL be single-cycle, registered pulses; a zero-wait write completes with no pulse.
REQ-031 Back-to-back requests SHALL be accepted on the first cycle ahb_busy is low.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, counter=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, HBURST=SINGLE, HPROT=HPROT_VAL, ahb_rd_data=0 and ahb_rd_vld=ahb_busy=bus_err=0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no completion pulse.

Structure
REQ-034 Package ahb_pkg SHALL hold the HTRANS codes (IDLE 00, NONSEQ 10), the HSIZE codes, HBURST SINGLE=000 and the FSM state encoding.
REQ-035 The block SHALL be a single module with no sub-module; the lane replication and timeout counter stay inline.

Verification
REQ-036 Word read at 0x0000_0010, zero-wait, HRDATA=0x1234_5678 -> HTRANS=NONSEQ one cycle, ahb_rd_vld at T+2 with 0x1234_5678, no bus_err.
REQ-037 Byte write 0xAB at 0x0000_0003, HREADY low 3 DATA cycles -> HWDATA=0xABAB_ABAB, HSIZE=000, ahb_busy high 5 cycles, no pulses.
REQ-038 Halfword read at 0x0000_0001 -> no NONSEQ issued, bus_err and ahb_rd_vld with data 0 one cycle later.
REQ-039 Read with two-cycle HRESP error response -> bus_err and ahb_rd_vld with data 0 after the second cycle; FSM returns to IDLE.
REQ-040 HREADY held low in DATA with TIMEOUT_CYCLES=4 -> abort after 4 cycles with bus_err; a request during busy is ignored; rst_n low mid-DATA -> all outputs at reset values immediately.
